// File: rtl/uart_disp_pkg.sv
// Shared constants and types for the UART digit display.
//   NUM_DIGITS : number of BCD digits held and scanned
//   SEG_BLANK  : active-low pattern with every segment off
//   SEG_LUT    : active-low {g,f,e,d,c,b,a} patterns for digits 0..9
//   bcd_t      : one BCD digit
package uart_disp_pkg;

   localparam int NUM_DIGITS = 4;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef logic [3:0] bcd_t;

   localparam logic [6:0] SEG_LUT [10] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
      7'h12, 7'h02, 7'h78, 7'h00, 7'h10
   };

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to seven-segment decoder, common-anode (active-low).
//   digit : 4-bit code
//   seg   : {g,f,e,d,c,b,a}, active-low; blank for codes 10..15
module seg7_decode
   import uart_disp_pkg::*;
(
   input  bcd_t       digit,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (digit <= 4'd9) begin
         seg = SEG_LUT[digit];
      end
   end

endmodule

// File: rtl/uart_digit_display.sv
// Collects decimal digits from the UART receiver into a 4-digit BCD shift
// buffer (newest on the right) and scans them onto a multiplexed
// common-anode seven-segment display. Non-decimal codes set a sticky error.
//   clk, rst    : system clock, asynchronous active-high reset
//   data        : received digit code
//   data_valid  : level from receiver; only its rising edge accepts a digit
//   clear       : synchronous clear of buffer, count and error
//   value_bcd   : buffer, [3:0] newest, [15:12] oldest
//   digit_count : digits held, 0..4, saturating
//   err         : sticky non-decimal flag
//   seg         : {g,f,e,d,c,b,a}, active-low
//   an          : digit enables, active-low, an[0] rightmost
module uart_digit_display
   import uart_disp_pkg::*;
#(
   parameter int CLK_FREQ   = 12000000,
   parameter int REFRESH_HZ = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  data,
   input  logic        data_valid,
   input  logic        clear,
   output logic [15:0] value_bcd,
   output logic [2:0]  digit_count,
   output logic        err,
   output logic [6:0]  seg,
   output logic [3:0]  an
);

   localparam int CLKS_PER_DIGIT = CLK_FREQ / REFRESH_HZ;
   localparam int PRE_W          = $clog2(CLKS_PER_DIGIT);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLKS_PER_DIGIT - 1);
   localparam logic [2:0]       COUNT_MAX = 3'(NUM_DIGITS);

   logic             dv_d;
   logic             accept;
   logic [PRE_W-1:0] prescale;
   logic [1:0]       scan_idx;
   bcd_t             digit_sel;
   logic [6:0]       seg_dec;

   assign accept = data_valid & ~dv_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dv_d <= 1'b0;
      end else begin
         dv_d <= data_valid;
      end
   end

   // Clear wins over a same-cycle accept, so the digit is dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value_bcd   <= '0;
         digit_count <= '0;
         err         <= 1'b0;
      end else if (clear) begin
         value_bcd   <= '0;
         digit_count <= '0;
         err         <= 1'b0;
      end else if (accept) begin
         if (data <= 4'd9) begin
            value_bcd <= {value_bcd[11:0], data};
            if (digit_count != COUNT_MAX) begin
               digit_count <= digit_count + 3'd1;
            end
         end else begin
            err <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prescale <= '0;
         scan_idx <= '0;
      end else if (prescale == PRE_LAST) begin
         prescale <= '0;
         scan_idx <= scan_idx + 2'd1;
      end else begin
         prescale <= prescale + 1'b1;
      end
   end

   assign digit_sel = value_bcd[4*scan_idx +: 4];

   seg7_decode u_decode (
      .digit (digit_sel),
      .seg   (seg_dec)
   );

   // Positions beyond the held digit count are blanked, but their anode
   // is still driven so the scan timing stays uniform.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg <= SEG_BLANK;
         an  <= 4'hF;
      end else begin
         an <= ~(4'b0001 << scan_idx);
         if ({1'b0, scan_idx} >= digit_count) begin
            seg <= SEG_BLANK;
         end else begin
            seg <= seg_dec;
         end
      end
   end

endmodule

// File: tb/tb_uart_digit_display.sv
module tb_uart_digit_display;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  data;
   logic        data_valid;
   logic        clear;
   logic [15:0] value_bcd;
   logic [2:0]  digit_count;
   logic        err;
   logic [6:0]  seg;
   logic [3:0]  an;

   int checks = 0;
   int errors = 0;

   uart_digit_display #(
      .CLK_FREQ   (1000),
      .REFRESH_HZ (100)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .data        (data),
      .data_valid  (data_valid),
      .clear       (clear),
      .value_bcd   (value_bcd),
      .digit_count (digit_count),
      .err         (err),
      .seg         (seg),
      .an          (an)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic pulse_digit(input logic [3:0] d);
      @(negedge clk);
      data       = d;
      data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic pulse_clear();
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      @(negedge clk);
   endtask

   // Waits (bounded) until the given anode is active, sampling on negedge.
   task automatic wait_an(input logic [3:0] target);
      logic found;
      found = 1'b0;
      for (int n = 0; n < 60 && !found; n++) begin
         @(negedge clk);
         if (an == target) found = 1'b1;
      end
      check("wait_an", {15'd0, found}, 16'd1);
   endtask

   task automatic check_seg_at(input string tag, input logic [3:0] target, input logic [6:0] exp);
      wait_an(target);
      check(tag, {9'd0, seg}, {9'd0, exp});
   endtask

   initial begin
      logic [3:0] exp_an;
      rst        = 1'b1;
      data       = 4'd0;
      data_valid = 1'b0;
      clear      = 1'b0;
      #7;
      check("rst_value", value_bcd, 16'h0000);
      check("rst_count", {13'd0, digit_count}, 16'd0);
      check("rst_err", {15'd0, err}, 16'd0);
      check("rst_seg", {9'd0, seg}, 16'h007F);
      check("rst_an", {12'd0, an}, 16'h000F);

      // Scan after release: E, D, B, 7, ten cycles each, all blank.
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         exp_an = ~(4'b0001 << (k / 10));
         check("scan_an", {12'd0, an}, {12'd0, exp_an});
         check("scan_seg", {9'd0, seg}, 16'h007F);
      end

      // Three digits.
      pulse_digit(4'd1);
      pulse_digit(4'd2);
      pulse_digit(4'd3);
      check("three_value", value_bcd, 16'h0123);
      check("three_count", {13'd0, digit_count}, 16'd3);
      check_seg_at("three_seg_e", 4'hE, 7'h30);
      check_seg_at("three_seg_d", 4'hD, 7'h24);
      check_seg_at("three_seg_b", 4'hB, 7'h79);
      check_seg_at("three_seg_7", 4'h7, 7'h7F);

      // Saturation.
      pulse_clear();
      for (int d = 1; d <= 5; d++) pulse_digit(4'(d));
      check("sat_value", value_bcd, 16'h2345);
      check("sat_count", {13'd0, digit_count}, 16'd4);
      check_seg_at("sat_seg_7", 4'h7, 7'h24);
      check_seg_at("sat_seg_e", 4'hE, 7'h12);

      // Error handling.
      pulse_clear();
      pulse_digit(4'd1);
      pulse_digit(4'd2);
      check("err_pre_value", value_bcd, 16'h0012);
      pulse_digit(4'hA);
      check("err_set", {15'd0, err}, 16'd1);
      check("err_value_kept", value_bcd, 16'h0012);
      check("err_count_kept", {13'd0, digit_count}, 16'd2);
      pulse_digit(4'd7);
      check("err_then_7", value_bcd, 16'h0127);
      check("err_sticky", {15'd0, err}, 16'd1);
      pulse_clear();
      check("clr_err", {15'd0, err}, 16'd0);
      check("clr_count", {13'd0, digit_count}, 16'd0);
      check("clr_value", value_bcd, 16'h0000);
      check_seg_at("clr_seg_e", 4'hE, 7'h7F);
      check_seg_at("clr_seg_7", 4'h7, 7'h7F);

      // Held valid: one shift per rising edge.
      @(negedge clk);
      data       = 4'd4;
      data_valid = 1'b1;
      repeat (50) @(negedge clk);
      data_valid = 1'b0;
      @(negedge clk);
      check("held_value", value_bcd, 16'h0004);
      check("held_count", {13'd0, digit_count}, 16'd1);
      pulse_digit(4'd4);
      check("held_second", value_bcd, 16'h0044);

      // Clear collides with an accept: the digit is dropped.
      @(negedge clk);
      data       = 4'd9;
      data_valid = 1'b1;
      clear      = 1'b1;
      @(negedge clk);
      clear      = 1'b0;
      data_valid = 1'b0;
      check("coll_value", value_bcd, 16'h0000);
      check("coll_count", {13'd0, digit_count}, 16'd0);

      // Reset mid-dwell with a populated buffer.
      pulse_digit(4'd8);
      check("pre_rst_value", value_bcd, 16'h0008);
      wait_an(4'hE);
      check("pre_rst_seg", {9'd0, seg}, 16'h0000);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_seg", {9'd0, seg}, 16'h007F);
      check("mid_rst_an", {12'd0, an}, 16'h000F);
      check("mid_rst_value", value_bcd, 16'h0000);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_an", {12'd0, an}, 16'h000E);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_digit_display.md
Name: uart_digit_display

Overview:
- Downstream consumer of the UART receive stage.
- Accepts 4-bit decimal digits (0–9) announced by `data_valid` and shifts them into a 4-digit BCD buffer, newest digit on the right.
- Drives a multiplexed, common-anode 4-digit seven-segment display.
- Flags non-decimal codes.

Parameters:
- `CLK_FREQ`, 12000000, system clock frequency in Hz.
- `REFRESH_HZ`, 1000, dwell rate per digit in Hz. `CLKS_PER_DIGIT = CLK_FREQ / REFRESH_HZ` (integer, must be ≥ 2).

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `data` in 4: received digit code from the UART receiver.
- `data_valid` in 1: level from the receiver; may stay high for many cycles; only its rising edge is meaningful.
- `clear` in 1: synchronous clear of buffer, count and error.
- `value_bcd` out 16: buffer; [3:0] is the newest digit, [15:12] the oldest.
- `digit_count` out 3: number of digits held, 0..4, saturating.
- `err` out 1: sticky, set by a non-decimal code.
- `seg` out 7: {g,f,e,d,c,b,a}, active-low.
- `an` out 4: digit enables, active-low, one-hot-low; `an[0]` is the rightmost digit.

Behaviour:
- Clock and reset: reset `rst`, asynchronous, active-high; clock `clk`. All state is in `clk` flip-flops.
- Reset values:
  - `value_bcd` = 0, `digit_count` = 0, `err` = 0.
  - `seg` = 7'h7F, `an` = 4'hF.
  - Prescaler = 0, scan index = 0, `dv_d` = 0.
- Accept detection:
  - Register `dv_d` <= `data_valid` every cycle.
  - `accept` = `data_valid` & ~`dv_d`. Exactly one accept per rising edge, regardless of high duration.
- On accept with `data` ≤ 9:
  - `value_bcd` <= {`value_bcd`[11:0], `data`}.
  - `digit_count` <= min(`digit_count` + 1, 4).
  - Visible on the next edge: 1-cycle latency from the `data_valid` rise.
- On accept with `data` ≥ 10:
  - `err` <= 1.
  - Buffer and count unchanged.
  - `err` stays 1 until `clear` or `rst`.
- `clear`:
  - Zeroes `value_bcd`, `digit_count` and `err` on the next edge.
  - Priority over a same-cycle accept; that digit is dropped.
  - Does not touch the prescaler or scan.
- Scan:
  - Prescaler counts 0..`CLKS_PER_DIGIT`-1 and wraps.
  - At terminal count, scan index (2 bits) increments 0→1→2→3→0.
- Registered outputs, updated every cycle from the current scan index `i`:
  - `an` <= ~(4'b0001 << `i`).
  - `seg` <= blank (7'h7F) if `i` ≥ `digit_count`, else decode(`value_bcd`[4i+3:4i]).
  - Outputs lag the index and buffer by one cycle.
  - A blanked position still has its `an` asserted.
- Decode (active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - Codes ≥ 10 never reach the buffer; the decoder still returns 7F for them.
- Reset mid-operation: all state returns to reset values immediately; the display blanks (`an` = F) until the first post-reset edge.

Decomposition:
- Package `uart_disp_pkg` holds:
  - `SEG_BLANK` = 7'h7F.
  - Ten-entry `SEG_LUT` constants.
  - `NUM_DIGITS` = 4.
  - BCD digit typedef (4-bit).
- One combinational sub-module, `seg7_decode` (4-bit in, 7-bit active-low out, blank for ≥ 10), is natural.
- Accept logic, buffer, prescaler and scan stay in the top module.

Test Plan:
- Bench runs with `CLK_FREQ` = 1000, `REFRESH_HZ` = 100, so `CLKS_PER_DIGIT` = 10.
- Reset and scan: after `rst` release, `an` cycles E, D, B, 7, each held 10 cycles; `seg` = 7F throughout; `value_bcd` = 0; `digit_count` = 0.
- Three digits: pulses with `data` = 1, 2, 3 → `value_bcd` = 0x0123, `digit_count` = 3; `seg` = 30 while `an` = E, 24 at D, 79 at B, 7F at 7.
- Saturation: five pulses 1..5 → `value_bcd` = 0x2345, `digit_count` = 4; `seg` = 24 while `an` = 7.
- Error: buffer 0x0012, then `data` = 0xA → `err` = 1, `value_bcd` still 0x0012. Then `data` = 7 → `value_bcd` = 0x0127, `err` still 1. Pulse `clear` → `err` = 0, `digit_count` = 0, all blank.
- Held valid: `data_valid` high 50 cycles with `data` = 4 → exactly one shift; `value_bcd` = 0x0004. A second rise → 0x0044.
- Collision: `clear` asserted in the same cycle as an accept of `data` = 9 → next cycle `value_bcd` = 0, `digit_count` = 0. Also assert `rst` mid-dwell → `seg` = 7F and `an` = F immediately.
